// File: rtl/adc_frame_packetizer.sv
// Captures a multi-channel sample word and streams it as one framed byte sequence:
// SYNC_BYTE, SEQ, then each channel MSB first. A test mode streams counter frames.
module adc_frame_packetizer #(
    parameter int          NUM_CHANNELS = 2,
    parameter int          SAMPLE_WIDTH = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst_n,
    input  logic                                 test_mode,
    input  logic                                 sample_strobe,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_data,
    output logic [7:0]                           tdata,
    output logic                                 tvalid,
    output logic                                 tlast,
    input  logic                                 tready,
    output logic                                 busy,
    output logic [15:0]                          drop_count
);
    localparam int BYTES_PER_CH = SAMPLE_WIDTH / 8;
    localparam int NUM_BYTES    = NUM_CHANNELS * BYTES_PER_CH;
    localparam int IDX_W        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int DW           = NUM_CHANNELS * SAMPLE_WIDTH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SYNC    = 2'd1;
    localparam logic [1:0] S_SEQ     = 2'd2;
    localparam logic [1:0] S_PAYLOAD = 2'd3;

    logic [1:0]              r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [7:0]              r_seq;
    logic [SAMPLE_WIDTH-1:0] r_pattern;
    logic [DW-1:0]           r_shadow;
    logic                    r_mode;
    logic [15:0]             r_drop;

    logic                    w_hs;
    logic                    w_last;
    logic                    w_window;
    logic                    w_start;
    logic                    w_drop;
    logic [DW-1:0]           w_pattern;
    logic [7:0]              w_bytes [NUM_BYTES];

    // Flatten the shadow word into transmit order so the payload index maps directly.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            assign w_pattern[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH] = r_pattern + SAMPLE_WIDTH'(gi);
            for (gj = 0; gj < BYTES_PER_CH; gj++) begin : g_byte
                assign w_bytes[gi*BYTES_PER_CH + gj] =
                    r_shadow[gi*SAMPLE_WIDTH + (BYTES_PER_CH-1-gj)*8 +: 8];
            end
        end
    endgenerate

    assign tvalid     = (r_state != S_IDLE);
    assign busy       = tvalid;
    assign w_hs       = tvalid & tready;
    assign w_last     = (r_state == S_PAYLOAD) && (r_idx == IDX_W'(NUM_BYTES-1));
    assign tlast      = w_last;
    assign w_window   = (r_state == S_IDLE) | (w_hs & w_last);
    assign w_start    = w_window & (test_mode | sample_strobe);
    // Outside the window the frame's own latched mode decides whether a strobe counts.
    assign w_drop     = ~w_window & sample_strobe & ~r_mode;
    assign drop_count = r_drop;

    always_comb begin
        tdata = 8'h00;
        case (r_state)
            S_SYNC:    tdata = SYNC_BYTE;
            S_SEQ:     tdata = r_seq;
            S_PAYLOAD: tdata = w_bytes[r_idx];
            default:   tdata = 8'h00;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_seq     <= 8'h00;
            r_pattern <= '0;
            r_shadow  <= '0;
            r_mode    <= 1'b0;
            r_drop    <= 16'h0000;
        end else begin
            if (w_start) begin
                r_mode <= test_mode;
                if (test_mode) begin
                    r_shadow  <= w_pattern;
                    r_pattern <= r_pattern + SAMPLE_WIDTH'(1);
                end else begin
                    r_shadow  <= sample_data;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) r_state <= S_SYNC;
                end
                S_SYNC: begin
                    if (w_hs) r_state <= S_SEQ;
                end
                S_SEQ: begin
                    if (w_hs) begin
                        r_state <= S_PAYLOAD;
                        r_seq   <= r_seq + 8'd1;
                        r_idx   <= '0;
                    end
                end
                default: begin
                    if (w_hs) begin
                        if (w_last) r_state <= w_start ? S_SYNC : S_IDLE;
                        else        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
            endcase

            if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
        end
    end
endmodule

// File: tb/tb_adc_frame_packetizer.sv
// Self-checking bench: fixed vector table, hand-written corner sequences and random
// traffic, all compared cycle by cycle against a queue-based frame model.
module tb_adc_frame_packetizer;
    localparam int         NC = 2;
    localparam int         SW = 16;
    localparam int         B  = SW / 8;
    localparam logic [7:0] SB = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        test_mode = 1'b0;
    logic        strobe = 1'b0;
    logic        tready = 1'b0;
    logic [31:0] sdata = 32'h0;
    logic [7:0]  tdata;
    logic        tvalid, tlast, busy;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    adc_frame_packetizer #(.NUM_CHANNELS(NC), .SAMPLE_WIDTH(SW), .SYNC_BYTE(SB)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .test_mode(test_mode),
        .sample_strobe(strobe), .sample_data(sdata),
        .tdata(tdata), .tvalid(tvalid), .tlast(tlast), .tready(tready),
        .busy(busy), .drop_count(drop_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bytes still owed for the frame in flight, plus counters.
    logic [7:0]  q[$];
    int          frames_m = 0;
    int          done_m = 0;
    logic [15:0] pat_m = 16'h0;
    logic        mode_m = 1'b0;
    int          drop_m = 0;
    bit          model_ok = 0;

    bit          prev_stall = 0;
    logic [7:0]  prev_data;
    logic        prev_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void build(input logic tm, input logic [31:0] d);
        logic [15:0] ch;
        q.push_back(SB);
        q.push_back(8'(frames_m));
        frames_m++;
        for (int c = 0; c < NC; c++) begin
            ch = tm ? pat_m + 16'(c) : d[c*SW +: SW];
            for (int j = 0; j < B; j++) q.push_back(8'(ch >> (8*(B-1-j))));
        end
        if (tm) pat_m++;
        mode_m = tm;
    endfunction

    function automatic void model_update(input logic rstn, input logic s, input logic tm,
                                         input logic r, input logic [31:0] d);
        bit bsy, hs, lst, win;
        if (!rstn) begin
            q.delete();
            frames_m = 0; pat_m = 16'h0; drop_m = 0; mode_m = 1'b0; model_ok = 1;
            return;
        end
        if (!model_ok) return;
        bsy = (q.size() > 0);
        hs  = bsy && r;
        lst = (q.size() == 1);
        win = !bsy || (hs && lst);
        if (hs) begin
            void'(q.pop_front());
            if (lst) begin
                done_m++;
                $display("frame %0d complete, drop_count model %0d", done_m, drop_m);
            end
        end
        if (win && (tm || s)) build(tm, d);
        else if (!win && s && !mode_m && drop_m < 65535) drop_m++;
    endfunction

    // One clock: compare outputs against the model, then drive the next inputs.
    task automatic step(input logic rstn, input logic s, input logic tm,
                        input logic r, input logic [31:0] d);
        @(negedge clk);
        if (model_ok) begin
            chk("tvalid", tvalid, q.size() > 0);
            chk("busy", busy, q.size() > 0);
            chk("drop_count", drop_count, drop_m);
            if (q.size() > 0) begin
                chk("tdata", tdata, q[0]);
                chk("tlast", tlast, q.size() == 1);
            end else begin
                chk("tlast_idle", tlast, 0);
            end
            if (prev_stall) begin
                chk("stall_tdata", tdata, prev_data);
                chk("stall_tlast", tlast, prev_last);
                chk("stall_tvalid", tvalid, 1);
            end
        end
        prev_stall = rstn && (tvalid === 1'b1) && !r;
        prev_data  = tdata;
        prev_last  = tlast;
        rst_n = rstn; strobe = s; test_mode = tm; tready = r; sdata = d;
        model_update(rstn, s, tm, r, d);
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() > 0 && g < 200) begin
            step(1, 0, 0, 1, 32'h0);
            g++;
        end
        chk("drain_bound", q.size(), 0);
    endtask

    typedef struct {
        logic        s;
        logic [31:0] d;
        logic        r;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic [15:0] edrop;
    } vec_t;

    vec_t       tbl [22];
    logic [7:0] texp [18];

    initial begin
        // Frame 1 (SEQ 00), then strobes where one lands mid-frame and one on tlast.
        tbl[0]  = '{1, 32'h1234ABCD, 1, 0, 8'h00, 0, 0};
        tbl[1]  = '{0, 32'h0, 1, 1, 8'hA5, 0, 0};
        tbl[2]  = '{0, 32'h0, 1, 1, 8'h00, 0, 0};
        tbl[3]  = '{0, 32'h0, 1, 1, 8'hAB, 0, 0};
        tbl[4]  = '{0, 32'h0, 1, 1, 8'hCD, 0, 0};
        tbl[5]  = '{0, 32'h0, 1, 1, 8'h12, 0, 0};
        tbl[6]  = '{0, 32'h0, 1, 1, 8'h34, 1, 0};
        tbl[7]  = '{0, 32'h0, 1, 0, 8'h00, 0, 0};
        tbl[8]  = '{1, 32'hCAFE0001, 1, 0, 8'h00, 0, 0};
        tbl[9]  = '{0, 32'h0, 1, 1, 8'hA5, 0, 0};
        tbl[10] = '{1, 32'hFFFFFFFF, 1, 1, 8'h01, 0, 0};
        tbl[11] = '{0, 32'h0, 1, 1, 8'h00, 0, 1};
        tbl[12] = '{0, 32'h0, 1, 1, 8'h01, 0, 1};
        tbl[13] = '{0, 32'h0, 1, 1, 8'hCA, 0, 1};
        tbl[14] = '{1, 32'h55557777, 1, 1, 8'hFE, 1, 1};
        tbl[15] = '{0, 32'h0, 1, 1, 8'hA5, 0, 1};
        tbl[16] = '{0, 32'h0, 1, 1, 8'h02, 0, 1};
        tbl[17] = '{0, 32'h0, 1, 1, 8'h77, 0, 1};
        tbl[18] = '{0, 32'h0, 1, 1, 8'h77, 0, 1};
        tbl[19] = '{0, 32'h0, 1, 1, 8'h55, 0, 1};
        tbl[20] = '{0, 32'h0, 1, 1, 8'h55, 1, 1};
        tbl[21] = '{0, 32'h0, 1, 0, 8'h00, 0, 1};
        texp = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                 8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02,
                 8'hA5, 8'h02, 8'h00, 8'h02, 8'h00, 8'h03};

        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 22; i++) begin
            step(1, tbl[i].s, 0, tbl[i].r, tbl[i].d);
            if (i == 0) chk("reset_tdata", tdata, 8'h00);
            chk("tbl_tvalid", tvalid, tbl[i].ev);
            chk("tbl_busy", busy, tbl[i].ev);
            chk("tbl_tlast", tlast, tbl[i].el);
            chk("tbl_drop", drop_count, tbl[i].edrop);
            if (tbl[i].ev) chk("tbl_tdata", tdata, tbl[i].ed);
        end

        // Stall pattern 1,0,0,1 repeating; stability is checked inside step.
        step(1, 1, 0, 1, 32'h1234ABCD);
        for (int i = 0; i < 40 && q.size() > 0; i++)
            step(1, 0, 0, (i % 4 == 0) || (i % 4 == 3), 32'h0);
        chk("toggle_drained", q.size(), 0);

        // Test mode right after reset: three contiguous counter frames.
        step(0, 0, 0, 0, 32'h0);
        step(1, 0, 1, 1, 32'h0);
        for (int i = 0; i < 18; i++) begin
            step(1, (i < 17) ? 1'($urandom % 2) : 1'b0, (i < 17), 1, $urandom);
            chk("test_byte", tdata, texp[i]);
            chk("test_tvalid", tvalid, 1);
        end
        step(1, 0, 0, 1, 32'h0);
        chk("test_idle", busy, 0);
        chk("test_drop", drop_count, 0);

        // 300 data frames: SEQ wraps through FF to 00.
        for (int f = 0; f < 300; f++) begin
            step(1, 1, 0, 1, $urandom);
            drain();
        end

        // Long stall with a strobe every cycle saturates the drop counter.
        step(1, 1, 0, 0, $urandom);
        for (int i = 0; i < 70000; i++) step(1, 1, 0, 0, $urandom);
        chk("drop_saturated", drop_count, 16'hFFFF);
        drain();

        // Reset during the payload of frame 3.
        step(0, 0, 0, 0, 32'h0);
        for (int g = 0; g < 60 && !(frames_m == 3 && q.size() == 3); g++)
            step(1, 1, 0, 1, $urandom);
        chk("reached_frame3", frames_m * 16 + q.size(), 3 * 16 + 3);
        step(0, 0, 0, 1, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_drop", drop_count, 0);
        step(1, 1, 0, 1, 32'h0BADF00D);
        step(1, 0, 0, 1, 32'h0);
        chk("rst_sync", tdata, SB);
        step(1, 0, 0, 1, 32'h0);
        chk("seq_after_reset", tdata, 8'h00);
        drain();

        // Random traffic: data mode, then test mode, then drain.
        for (int i = 0; i < 2000; i++)
            step(1, ($urandom % 4) == 0, 0, ($urandom % 3) != 0, $urandom);
        for (int i = 0; i < 300; i++)
            step(1, 1'($urandom % 2), 1, ($urandom % 4) != 0, $urandom);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
